// File: rtl/rr_req_encoder.sv
// ---------------------------------------------------------------------------
// rr_req_encoder
//
// Sequential 4-to-2 request encoder. Incoming request bits are merged into a
// pending register; one pending request is selected (round-robin or fixed
// priority) and its 2-bit index is offered on a valid/ready handshake. The
// one-hot form of the offered index is provided alongside so a downstream
// 2-to-4 decoder result can be round-tripped.
//
// Handshake: valid/ready. A transfer happens in any cycle where valid and
// ready are both high at the rising clock edge. While valid is high and ready
// is low, idx and valid hold stable (no retraction, no re-selection). Ready is
// ignored while valid is low.
//
// Parameters
//   RR_EN     1 = round-robin priority, 0 = fixed priority (index 0 highest)
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-high
//   req       request bits; bit i high in a cycle marks request i pending
//   ready     consumer accepts the offered index when high together with valid
//   valid     idx holds a granted request
//   idx       encoded index of the granted request
//   grant_oh  one-hot of idx when valid, zero otherwise
//   pend      current pending-request register
//   ovf       one-cycle pulse: a request hit a bit that was already pending
//             and not being cleared that cycle (request merged)
// ---------------------------------------------------------------------------
module rr_req_encoder #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ready,
    output logic       valid,
    output logic [1:0] idx,
    output logic [3:0] grant_oh,
    output logic [3:0] pend,
    output logic       ovf
);

    // valid is high exactly in HOLD, so the state is directly observable.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q,   idx_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] pend_q,  pend_d;
    logic       ovf_q,   ovf_d;

    logic       acc;
    logic [3:0] clr;
    logic [3:0] remain;
    logic [1:0] idle_base;
    logic [1:0] next_base;

    // First set bit of v, searching p, p+1, ... with wrap from 3 to 0.
    // Iterating from the farthest offset down lets the nearest hit win.
    function automatic logic [1:0] sel_f(input logic [3:0] v, input logic [1:0] p);
        logic [1:0] j;
        logic [1:0] r;
        r = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            j = p + 2'(k);
            if (v[j]) begin
                r = j;
            end
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Handshake and pending-register datapath
    // -----------------------------------------------------------------------
    assign acc = (state_q == HOLD) && ready;
    assign clr = acc ? (4'b0001 << idx_q) : 4'b0000;

    // Pending bits that survive this cycle's accept, excluding new requests.
    assign remain = pend_q & ~clr;

    // A new request on a bit being cleared this cycle simply re-arms it.
    assign pend_d = remain | req;
    assign ovf_d  = |(req & remain);

    // Fixed priority always searches from index 0.
    assign idle_base = RR_EN ? ptr_q : 2'd0;
    assign next_base = RR_EN ? (idx_q + 2'd1) : 2'd0;

    // -----------------------------------------------------------------------
    // State register (also holds the datapath registers)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            ptr_q   <= 2'd0;
            pend_q  <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    idx_d   = sel_f(pend_q, idle_base);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (acc) begin
                    // Pointer moves past the index just served; the next
                    // idle search then starts there.
                    if (RR_EN) begin
                        ptr_d = idx_q + 2'd1;
                    end
                    // Back-to-back grant from what remains pending; requests
                    // arriving this cycle are only seen next cycle via pend.
                    if (|remain) begin
                        idx_d = sel_f(remain, next_base);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        valid    = (state_q == HOLD);
        idx      = idx_q;
        pend     = pend_q;
        ovf      = ovf_q;
        grant_oh = valid ? (4'b0001 << idx_q) : 4'b0000;
    end

endmodule
